counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 114 +++++++++++
 tb/tb_counter_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Run/pause/abort controlled up-counter with one-shot or auto-reload wrap,
// a registered terminal-count pulse and a saturating wrap counter.
module counter_ctrl #(
    parameter int WIDTH  = 4,
    parameter int RWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [WIDTH-1:0]  limit,
    input  logic              auto_reload,
    output logic [WIDTH-1:0]  counter,
    output logic              busy,
    output logic              done,
    output logic [RWIDTH-1:0] reload_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RWIDTH-1:0] RLD_ONE = {{(RWIDTH-1){1'b0}}, 1'b1};
    localparam logic [RWIDTH-1:0] RLD_MAX = {RWIDTH{1'b1}};

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  counter_nxt;
    logic [WIDTH-1:0]  limit_q, limit_nxt;
    logic              mode_q, mode_nxt;
    logic              done_nxt;
    logic [RWIDTH-1:0] reload_nxt;
    logic              at_limit;

    assign at_limit  = (counter == limit_q);
    assign busy      = (state == RUN) || (state == PAUSED);
    assign state_dbg = state;

    // Priority per edge: abort, then pause, then count/terminal handling.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        reload_nxt  = reload_cnt;
        limit_nxt   = limit_q;
        mode_nxt    = mode_q;
        done_nxt    = 1'b0;
        if (abort) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
            reload_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt   = RUN;
                        counter_nxt = '0;
                        reload_nxt  = '0;
                        limit_nxt   = limit;
                        mode_nxt    = auto_reload;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (at_limit) begin
                        done_nxt = 1'b1;
                        if (mode_q) begin
                            counter_nxt = '0;
                            if (reload_cnt != RLD_MAX) reload_nxt = reload_cnt + RLD_ONE;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        counter_nxt = counter + CNT_ONE;
                    end
                end
                PAUSED: begin
                    // Resuming costs the edge; the count restarts on the next one.
                    if (!pause) state_nxt = RUN;
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            reload_cnt <= '0;
            done       <= 1'b0;
            limit_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            reload_cnt <= reload_nxt;
            done       <= done_nxt;
            limit_q    <= limit_nxt;
            mode_q     <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: per-cycle directed vectors push expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_counter_ctrl;

    localparam int W = 16;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic       clk = 1'b0;
    logic       reset, start, pause, abort, auto_reload;
    logic [3:0] limit;
    logic [3:0] counter;
    logic       busy, done;
    logic [7:0] reload_cnt;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    counter_ctrl #(.WIDTH(4), .RWIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .limit(limit), .auto_reload(auto_reload), .counter(counter), .busy(busy),
        .done(done), .reload_cnt(reload_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, want end before 2 ms");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pack(input logic [1:0] st, input logic [3:0] cnt,
                                          input logic dn, input logic [7:0] rc);
        logic bz;
        bz = (st == S_RUN) || (st == S_PAUSED);
        return {st, cnt, bz, dn, rc};
    endfunction

    function automatic logic [W-1:0] actual();
        return {state_dbg, counter, busy, done, reload_cnt};
    endfunction

    task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got st=%0d cnt=%0d busy=%0b done=%0b rc=%0d, want st=%0d cnt=%0d busy=%0b done=%0b rc=%0d",
                     name, got[15:14], got[13:10], got[9], got[8], got[7:0],
                     want[15:14], want[13:10], want[9], want[8], want[7:0]);
        end
    endtask

    // driver: inputs for the next rising edge plus the outputs expected after it
    task automatic cyc(input logic s, input logic p, input logic a, input logic [3:0] lim,
                       input logic ar, input logic [1:0] es, input logic [3:0] ec,
                       input logic ed, input logic [7:0] er);
        @(negedge clk);
        #1;
        start = s; pause = p; abort = a; limit = lim; auto_reload = ar;
        exp_q.push_back(pack(es, ec, ed, er));
    endtask

    // scoreboard monitor
    initial begin
        int n;
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            n = exp_q.size();
            @(negedge clk);
            if (n > 0) begin
                e = exp_q.pop_front();
                compare("cycle", actual(), e);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        limit = 4'd0; auto_reload = 1'b0;
        #1;
        compare("reset_async_init", actual(), pack(S_IDLE, 4'd0, 1'b0, 8'd0));
        #19 reset = 1'b0;
        #1;
        compare("reset_release", actual(), pack(S_IDLE, 4'd0, 1'b0, 8'd0));

        // idle with no start
        repeat (3) cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);

        // one-shot limit=3; start during DONE is ignored; counter holds in IDLE
        cyc(1, 0, 0, 4'd3, 0, S_RUN,  4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd1, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd2, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd3, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_DONE, 4'd3, 1, 8'd0);
        cyc(1, 0, 0, 4'd9, 1, S_IDLE, 4'd3, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd3, 0, 8'd0);

        // auto-reload limit=2, mid-run start with new limit ignored, then abort
        cyc(1, 0, 0, 4'd2, 1, S_RUN, 4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd1, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd2, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd0, 1, 8'd1);
        cyc(1, 0, 0, 4'd7, 0, S_RUN, 4'd1, 0, 8'd1);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd2, 0, 8'd1);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd0, 1, 8'd2);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd1, 0, 8'd2);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd2, 0, 8'd2);
        cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd0, 1, 8'd3);
        cyc(0, 0, 1, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);

        // one-shot limit=5, pause ignored on start edge, then paused 3 edges at 2
        cyc(1, 1, 0, 4'd5, 0, S_RUN,    4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd1, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd2, 0, 8'd0);
        cyc(0, 1, 0, 4'd0, 0, S_PAUSED, 4'd2, 0, 8'd0);
        cyc(1, 1, 0, 4'd1, 0, S_PAUSED, 4'd2, 0, 8'd0);
        cyc(0, 1, 0, 4'd0, 0, S_PAUSED, 4'd2, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd2, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd3, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd4, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd5, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_DONE,   4'd5, 1, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE,   4'd5, 0, 8'd0);

        // auto-reload limit=4, start with other limit ignored, abort at counter=3
        cyc(1, 0, 0, 4'd4, 1, S_RUN,  4'd0, 0, 8'd0);
        cyc(1, 0, 0, 4'd1, 0, S_RUN,  4'd1, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd2, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd3, 0, 8'd0);
        cyc(0, 0, 1, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);

        // one-shot limit=0: done after one RUN cycle
        cyc(1, 0, 0, 4'd0, 0, S_RUN,  4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_DONE, 4'd0, 1, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);

        // auto-reload limit=0: done every cycle, pause, abort+start, start+abort in IDLE
        cyc(1, 0, 0, 4'd0, 1, S_RUN,    4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd0, 1, 8'd1);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd0, 1, 8'd2);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd0, 1, 8'd3);
        cyc(0, 1, 0, 4'd0, 0, S_PAUSED, 4'd0, 0, 8'd3);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd0, 0, 8'd3);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,    4'd0, 1, 8'd4);
        cyc(1, 0, 1, 4'd0, 0, S_IDLE,   4'd0, 0, 8'd0);
        cyc(1, 0, 1, 4'd3, 0, S_IDLE,   4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE,   4'd0, 0, 8'd0);

        // reload_cnt saturation at 255
        cyc(1, 0, 0, 4'd0, 1, S_RUN, 4'd0, 0, 8'd0);
        for (int i = 1; i <= 260; i++)
            cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'd0, 1, (i > 255) ? 8'd255 : 8'(i));
        cyc(0, 0, 1, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);

        // async reset mid-run at counter=7, limit=15
        cyc(1, 0, 0, 4'd15, 0, S_RUN, 4'd0, 0, 8'd0);
        for (int i = 1; i <= 7; i++)
            cyc(0, 0, 0, 4'd0, 0, S_RUN, 4'(i), 0, 8'd0);
        @(negedge clk);
        #1;
        compare("pre_reset_count", actual(), pack(S_RUN, 4'd7, 1'b0, 8'd0));
        #1 reset = 1'b1;
        #1;
        compare("async_reset_midrun", actual(), pack(S_IDLE, 4'd0, 1'b0, 8'd0));
        @(posedge clk);
        #1;
        compare("reset_held_edge", actual(), pack(S_IDLE, 4'd0, 1'b0, 8'd0));
        @(negedge clk);
        #2 reset = 1'b0;
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd0, 0, 8'd0);
        cyc(1, 0, 0, 4'd1, 0, S_RUN,  4'd0, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_RUN,  4'd1, 0, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_DONE, 4'd1, 1, 8'd0);
        cyc(0, 0, 0, 4'd0, 0, S_IDLE, 4'd1, 0, 8'd0);

        // drain the expected queue within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
